peri_bus_arbiter: RTL and testbench

- Parametrised N-core peripheral-bus arbiter; successor to the current multicore top, where only PE0 reaches peripherals and the other PEs have their peripheral inputs tied off.
- Sits between the per-PE NanoCore_Wrapper peripheral ports and the single SoC peripheral bus.
- Round-robin fair among enabled PEs; one outstanding transaction; response routed back to the owning PE.

---
 rtl/peri_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_peri_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus among NUM_PE cores; optional timeout via PERI_ARB_TIMEOUT_EN.
// Latency: gnt in the request cycle, downstream request one cycle later, PE response one cycle after i_peri_ready.
// Backpressure: one transaction in flight; unserved PEs hold their level requests until o_pe_gnt pulses.
module peri_bus_arbiter #(
  parameter int NUM_PE      = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_PE-1:0]          i_core_en,
  input  logic [NUM_PE-1:0]          i_pe_rden,
  input  logic [NUM_PE-1:0]          i_pe_wren,
  input  logic [NUM_PE*ADDR_W-1:0]   i_pe_addr,
  input  logic [NUM_PE*DATA_W-1:0]   i_pe_wdata,
  input  logic [NUM_PE*DATA_W/8-1:0] i_pe_wstrb,
  output logic [NUM_PE-1:0]          o_pe_gnt,
  output logic [NUM_PE-1:0]          o_pe_ready,
  output logic [DATA_W-1:0]          o_pe_rdata,
  output logic                       o_peri_rden,
  output logic                       o_peri_wren,
  output logic [ADDR_W-1:0]          o_peri_addr,
  output logic [DATA_W-1:0]          o_peri_wdata,
  output logic [DATA_W/8-1:0]        o_peri_wstrb,
  input  logic                       i_peri_gnt,
  input  logic                       i_peri_ready,
  input  logic [DATA_W-1:0]          i_peri_rdata,
`ifdef PERI_ARB_TIMEOUT_EN
  output logic                       o_timeout_err,
`endif
  output logic [((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] o_owner
);

  localparam int OW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int SW = DATA_W / 8;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

  if (NUM_PE < 1 || NUM_PE > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("peri_bus_arbiter: NUM_PE must be 1..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [NUM_PE-1:0] act;
  logic              any_act;
  logic [OW-1:0]     win;
  logic [OW-1:0]     ptr;
  logic              is_wr;
  logic              lost;
  logic [DATA_W-1:0] rdata_q;
  logic [NUM_PE-1:0] gnt_c;
  logic [NUM_PE-1:0] ready_c;
  logic              take_rsp;
  logic              tmo;
  logic              tmo_fire;

  // A write wins over a simultaneous read, so wren alone decides the type.
  assign act = i_core_en & (i_pe_rden | i_pe_wren);

  // Pick the first active PE strictly after the last winner, wrapping around.
  always_comb begin
    any_act = 1'b0;
    win     = '0;
    for (int i = 1; i <= NUM_PE; i++) begin
      if (!any_act && act[(int'(ptr) + i) % NUM_PE]) begin
        any_act = 1'b1;
        win     = OW'((int'(ptr) + i) % NUM_PE);
      end
    end
  end

`ifdef PERI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  // Cycles spent in the current ISSUE/WAIT visit; restarts on every state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (state_n != state) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE || state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign tmo = (state == S_ISSUE || state == S_WAIT) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  // Error flag coincides with the RESP cycle that a timeout produced.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_timeout_err <= 1'b0;
    else       o_timeout_err <= tmo_fire;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, combinational grant and response strobe.
  always_comb begin
    state_n  = state;
    gnt_c    = '0;
    ready_c  = '0;
    take_rsp = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_act) begin
          state_n    = S_ISSUE;
          gnt_c[win] = 1'b1;
        end
      end
      S_ISSUE: begin
        if (i_peri_gnt && i_peri_ready) begin
          state_n  = S_RESP;
          take_rsp = 1'b1;
        end else if (i_peri_gnt) begin
          state_n = S_WAIT;
        end else if (tmo) begin
          state_n  = S_RESP;
          tmo_fire = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_peri_ready) begin
          state_n  = S_RESP;
          take_rsp = 1'b1;
        end else if (tmo) begin
          state_n  = S_RESP;
          tmo_fire = 1'b1;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
        if (!lost && i_core_en[owner_idx()]) ready_c[owner_idx()] = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // Grant is combinational, so it must also vanish the instant reset rises.
    if (i_rst) gnt_c = '0;
  end

  function automatic logic [OW-1:0] owner_idx();
    return o_owner;
  endfunction

  assign o_pe_gnt   = gnt_c;
  assign o_pe_ready = ready_c;
  assign o_pe_rdata = rdata_q;

  // Capture the winner's request, drive the downstream bus and latch the response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr          <= '0;
      o_owner      <= '0;
      is_wr        <= 1'b0;
      lost         <= 1'b0;
      rdata_q      <= '0;
      o_peri_rden  <= 1'b0;
      o_peri_wren  <= 1'b0;
      o_peri_addr  <= '0;
      o_peri_wdata <= '0;
      o_peri_wstrb <= '0;
    end else begin
      if (state == S_IDLE && any_act) begin
        ptr          <= win;
        o_owner      <= win;
        is_wr        <= i_pe_wren[win];
        lost         <= 1'b0;
        o_peri_wren  <= i_pe_wren[win];
        o_peri_rden  <= ~i_pe_wren[win];
        o_peri_addr  <= i_pe_addr[int'(win)*ADDR_W +: ADDR_W];
        o_peri_wdata <= i_pe_wdata[int'(win)*DATA_W +: DATA_W];
        o_peri_wstrb <= i_pe_wstrb[int'(win)*SW +: SW];
      end
      // A PE disabled mid-transaction forfeits its response; the bus cycle still finishes.
      if ((state == S_ISSUE || state == S_WAIT) && !i_core_en[o_owner]) lost <= 1'b1;
      if ((state == S_ISSUE && i_peri_gnt) || tmo_fire) begin
        o_peri_rden <= 1'b0;
        o_peri_wren <= 1'b0;
      end
      if (take_rsp)      rdata_q <= is_wr ? '0 : i_peri_rdata;
      else if (tmo_fire) rdata_q <= DATA_W'(BEEF);
    end
  end

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Directed bench for peri_bus_arbiter with 4 PEs and a 16-cycle timeout.
// Latency: inputs driven on the falling edge, outputs checked 1 time unit later.
// Backpressure: downstream gnt/ready are scripted per cycle by the bench.
module tb_peri_bus_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  core_en, pe_rden, pe_wren;
  logic [N*32-1:0] pe_addr, pe_wdata;
  logic [N*4-1:0]  pe_wstrb;
  logic [N-1:0]  pe_gnt, pe_ready;
  logic [31:0]   pe_rdata;
  logic          peri_rden, peri_wren;
  logic [31:0]   peri_addr, peri_wdata;
  logic [3:0]    peri_wstrb;
  logic          peri_gnt, peri_ready;
  logic [31:0]   peri_rdata;
  logic [1:0]    owner;
`ifdef PERI_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  peri_bus_arbiter #(.NUM_PE(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_core_en(core_en),
    .i_pe_rden(pe_rden), .i_pe_wren(pe_wren), .i_pe_addr(pe_addr),
    .i_pe_wdata(pe_wdata), .i_pe_wstrb(pe_wstrb),
    .o_pe_gnt(pe_gnt), .o_pe_ready(pe_ready), .o_pe_rdata(pe_rdata),
    .o_peri_rden(peri_rden), .o_peri_wren(peri_wren), .o_peri_addr(peri_addr),
    .o_peri_wdata(peri_wdata), .o_peri_wstrb(peri_wstrb),
    .i_peri_gnt(peri_gnt), .i_peri_ready(peri_ready), .i_peri_rdata(peri_rdata),
`ifdef PERI_ARB_TIMEOUT_EN
    .o_timeout_err(timeout_err),
`endif
    .o_owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entry: IDLE cycle with requests applied. Downstream accepts and answers in the ISSUE cycle.
  task automatic fast_txn(input logic [3:0] exp_gnt, input logic [1:0] exp_owner, input logic [31:0] rd);
    #1 chk("gnt", pe_gnt, exp_gnt);
    step();
    peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = rd;
    #1 chk("issue_req", peri_rden | peri_wren, 1);
    chk("owner", owner, exp_owner);
    chk("gnt_in_issue", pe_gnt, 0);
    step();
    peri_gnt = 1'b0; peri_ready = 1'b0;
    #1 chk("resp_ready", pe_ready, exp_gnt);
    chk("resp_rdata", pe_rdata, rd);
    chk("resp_no_gnt", pe_gnt, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    core_en = '0; pe_rden = '0; pe_wren = '0;
    pe_addr = '0; pe_wdata = '0; pe_wstrb = '0;
    peri_gnt = 1'b0; peri_ready = 1'b0; peri_rdata = '0;
    step(); step();
    #1 chk("rst_gnt", pe_gnt, 0);
    chk("rst_ready", pe_ready, 0);
    chk("rst_rden", peri_rden, 0);
    chk("rst_wren", peri_wren, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdata", pe_rdata, 0);
    chk("rst_addr", peri_addr, 0);
    step();
    rst = 1'b0;
    core_en = 4'hF;

    // Stray downstream ready while idle must not produce a response.
    peri_ready = 1'b1; peri_rdata = 32'h1111_1111;
    step();
    peri_ready = 1'b0;
    #1 chk("stray_ready", pe_ready, 0);

    // PE2 read: gnt at 0, downstream gnt at 1, ready at 3, response at 4.
    pe_rden[2] = 1'b1;
    pe_addr[2*32 +: 32] = 32'h1000_0010;
    #1 chk("t1_gnt", pe_gnt, 4'b0100);
    step();
    pe_rden = '0; peri_gnt = 1'b1;
    #1 chk("t1_rden", peri_rden, 1);
    chk("t1_addr", peri_addr, 32'h1000_0010);
    chk("t1_owner", owner, 2);
    step();
    peri_gnt = 1'b0;
    #1 chk("t1_rden_drop", peri_rden, 0);
    step();
    peri_ready = 1'b1; peri_rdata = 32'h1234_5678;
    #1 chk("t1_ready_early", pe_ready, 0);
    step();
    peri_ready = 1'b0;
    #1 chk("t1_ready", pe_ready, 4'b0100);
    chk("t1_rdata", pe_rdata, 32'h1234_5678);
    step();
    #1 chk("t1_ready_once", pe_ready, 0);

    // Reset the pointer, then all PEs request continuously.
    rst = 1'b1;
    step();
    rst = 1'b0;
    pe_rden = 4'hF;
    fast_txn(4'b0010, 2'd1, 32'h0000_0001);
    fast_txn(4'b0100, 2'd2, 32'h0000_0002);
    fast_txn(4'b1000, 2'd3, 32'h0000_0003);
    fast_txn(4'b0001, 2'd0, 32'h0000_0004);
    fast_txn(4'b0010, 2'd1, 32'h0000_0005);

    // PE0 rden+wren together is a write; its response carries zero data.
    pe_rden = 4'b0001; pe_wren = 4'b0001;
    pe_wdata[31:0] = 32'hA5A5_A5A5; pe_wstrb[3:0] = 4'hF;
    #1 chk("t3_gnt", pe_gnt, 4'b0001);
    step();
    pe_rden = '0; pe_wren = '0; peri_gnt = 1'b1;
    #1 chk("t3_wren", peri_wren, 1);
    chk("t3_rden", peri_rden, 0);
    chk("t3_wdata", peri_wdata, 32'hA5A5_A5A5);
    chk("t3_wstrb", peri_wstrb, 4'hF);
    step();
    peri_gnt = 1'b0; peri_ready = 1'b1; peri_rdata = 32'hFFFF_FFFF;
    step();
    peri_ready = 1'b0;
    #1 chk("t3_ready", pe_ready, 4'b0001);
    chk("t3_rdata", pe_rdata, 0);
    step();

    // PE1 disabled while in WAIT: no response, next grant goes to PE2.
    pe_rden = 4'b0111;
    #1 chk("t4_gnt", pe_gnt, 4'b0010);
    step();
    pe_rden = 4'b0101; peri_gnt = 1'b1;
    #1 chk("t4_owner", owner, 1);
    step();
    peri_gnt = 1'b0; core_en = 4'b1101;
    step();
    peri_ready = 1'b1; peri_rdata = 32'h0000_CAFE;
    #1 chk("t4_wait_ready", pe_ready, 0);
    step();
    peri_ready = 1'b0;
    #1 chk("t4_suppressed", pe_ready, 0);
    step();
    #1 chk("t4_next_gnt", pe_gnt, 4'b0100);
    step();
    pe_rden = '0; peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = 32'h0000_0022;
    step();
    peri_gnt = 1'b0; peri_ready = 1'b0;
    #1 chk("t4_pe2_ready", pe_ready, 4'b0100);
    step();
    core_en = 4'hF;

    // Asynchronous reset while in WAIT, with PE0 already requesting.
    pe_rden = 4'b1000;
    #1 chk("t5_gnt", pe_gnt, 4'b1000);
    step();
    pe_rden = '0; peri_gnt = 1'b1;
    step();
    peri_gnt = 1'b0; pe_rden = 4'b0001;
    #1 chk("t5_owner_wait", owner, 3);
    #1 rst = 1'b1;
    #1 chk("t5_async_owner", owner, 0);
    chk("t5_async_gnt", pe_gnt, 0);
    chk("t5_async_ready", pe_ready, 0);
    chk("t5_async_rden", peri_rden, 0);
    chk("t5_async_wren", peri_wren, 0);
    step();
    rst = 1'b0;
    fast_txn(4'b0001, 2'd0, 32'h55AA_0FF0);
    pe_rden = '0;

`ifdef PERI_ARB_TIMEOUT_EN
    // Downstream accepts but never answers: timeout after 16 WAIT cycles.
    pe_rden = 4'b0010;
    #1 chk("t6_gnt", pe_gnt, 4'b0010);
    step();
    pe_rden = '0; peri_gnt = 1'b1;
    step();
    peri_gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("t6_wait", {pe_ready, timeout_err}, 0);
      step();
    end
    #1 chk("t6_ready", pe_ready, 4'b0010);
    chk("t6_rdata", pe_rdata, 32'hDEAD_BEEF);
    chk("t6_err", timeout_err, 1);
    step();
    peri_ready = 1'b1; peri_rdata = 32'h7777_7777;
    #1 chk("t6_err_once", timeout_err, 0);
    step();
    peri_ready = 1'b0;
    #1 chk("t6_late_ready", pe_ready, 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
